// File: rtl/run_control.sv
`timescale 1ns/1ps
// run_control: front-panel execution sequencer for the 6502.
// Converts debounced keypad pulses into the CPU control pins RDY, RESn and NMIn.
// The CPU is halted at instruction boundaries by holding RDY low during the
// opcode-fetch cycle (SYNC high). The same mechanism lets it execute one
// instruction per step request.
//
// Ports:
//   clk        25 MHz system clock
//   rst_n      asynchronous active-low reset
//   phi2       PHI2, already synchronized to clk
//   sync       6502 SYNC, already synchronized to clk
//   b_runhalt  one-clk pulse, toggles run/halt
//   b_step     one-clk pulse, execute one instruction while halted
//   b_reset    one-clk pulse, reset the CPU
//   b_nmi      one-clk pulse, request an NMI
//   rdy        6502 RDY (0 stalls read cycles)
//   res_n      6502 RESn
//   nmi_n      6502 NMIn, active low
//   led_run    lit in RUN or HALTING
//   led_halt   lit in HALTED or either step state
//   busy       high in any state other than RUN and HALTED
module run_control #(
  parameter int unsigned RESET_CYCLES = 8,
  parameter int unsigned NMI_WIDTH    = 128,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic phi2,
  input  logic sync,
  input  logic b_runhalt,
  input  logic b_step,
  input  logic b_reset,
  input  logic b_nmi,
  output logic rdy,
  output logic res_n,
  output logic nmi_n,
  output logic led_run,
  output logic led_halt,
  output logic busy
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam int NCW = (NMI_WIDTH > 1) ? $clog2(NMI_WIDTH + 1) : 1;

  // The reset counter stops one short of RESET_CYCLES: the fe that would
  // reach RESET_CYCLES is the one that releases res_n.
  localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);
  localparam logic [NCW-1:0] NMI_LAST = NCW'(NMI_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_RUN        = 3'd1,
    ST_HALTING    = 3'd2,
    ST_HALTED     = 3'd3,
    ST_STEP_LEAVE = 3'd4,
    ST_STEP_WAIT  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic             mode_halt_q, mode_halt_d;
  logic             phi2_q;
  logic [NCW-1:0]   nmi_cnt_q, nmi_cnt_d;
  logic             nmi_n_q, nmi_n_d;
  logic             rdy_q, rdy_d;
  logic             res_n_q, res_n_d;
  logic             led_run_q, led_run_d;
  logic             led_halt_q, led_halt_d;
  logic             busy_q, busy_d;

  logic fe;
  logic bnd;

  assign fe  = phi2_q & ~phi2;
  // Opcode fetch in PHI1: pulling RDY now still stalls this fetch.
  assign bnd = sync & ~phi2;

  // Next-state logic: b_reset preempts everything, then run/halt, then step.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    mode_halt_d = mode_halt_q;
    if (b_reset) begin
      state_d   = ST_RESET;
      rst_cnt_d = '0;
      // Remember whether the user was halted so the reset handler stops at
      // its first instruction; a reset during RESET keeps the earlier choice.
      case (state_q)
        ST_RUN, ST_HALTING:                       mode_halt_d = 1'b0;
        ST_HALTED, ST_STEP_LEAVE, ST_STEP_WAIT:   mode_halt_d = 1'b1;
        default:                                  mode_halt_d = mode_halt_q;
      endcase
    end else begin
      case (state_q)
        ST_RESET: begin
          if (fe) begin
            if (rst_cnt_q == RST_LAST) begin
              state_d = mode_halt_q ? ST_HALTING : ST_RUN;
            end else begin
              rst_cnt_d = rst_cnt_q + RCW'(32'd1);
            end
          end else begin
            rst_cnt_d = rst_cnt_q;
          end
        end
        ST_RUN: begin
          if (b_runhalt) begin
            state_d = ST_HALTING;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALTING: begin
          if (b_runhalt) begin
            state_d = ST_RUN;
          end else if (bnd) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_HALTING;
          end
        end
        ST_HALTED: begin
          if (b_runhalt) begin
            state_d = ST_RUN;
          end else if (b_step) begin
            state_d = ST_STEP_LEAVE;
          end else begin
            state_d = ST_HALTED;
          end
        end
        ST_STEP_LEAVE: begin
          // SYNC is still high from the stalled fetch; wait for that cycle
          // to end before looking for the next boundary.
          if (b_runhalt) begin
            state_d = ST_RUN;
          end else if (fe) begin
            state_d = ST_STEP_WAIT;
          end else begin
            state_d = ST_STEP_LEAVE;
          end
        end
        ST_STEP_WAIT: begin
          if (b_runhalt) begin
            state_d = ST_RUN;
          end else if (bnd) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_STEP_WAIT;
          end
        end
        default: begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
        end
      endcase
    end
  end

  // Output decode from the next state, so every pin is a flop output.
  always_comb begin
    rdy_d      = 1'b1;
    res_n_d    = 1'b1;
    led_run_d  = 1'b0;
    led_halt_d = 1'b0;
    busy_d     = 1'b1;
    case (state_d)
      ST_RESET: begin
        res_n_d = 1'b0;
      end
      ST_RUN: begin
        led_run_d = 1'b1;
        busy_d    = 1'b0;
      end
      ST_HALTING: begin
        led_run_d = 1'b1;
      end
      ST_HALTED: begin
        rdy_d      = 1'b0;
        led_halt_d = 1'b1;
        busy_d     = 1'b0;
      end
      ST_STEP_LEAVE, ST_STEP_WAIT: begin
        led_halt_d = 1'b1;
      end
      default: begin
        res_n_d = 1'b0;
      end
    endcase
  end

  // NMI pulse generator: non-retriggerable, independent of b_reset.
  always_comb begin
    nmi_n_d   = nmi_n_q;
    nmi_cnt_d = nmi_cnt_q;
    if (!nmi_n_q) begin
      if (nmi_cnt_q == '0) begin
        nmi_n_d = 1'b1;
      end else begin
        nmi_cnt_d = nmi_cnt_q - NCW'(32'd1);
      end
    end else if (b_nmi) begin
      nmi_n_d   = 1'b0;
      nmi_cnt_d = NMI_LAST;
    end else begin
      nmi_cnt_d = nmi_cnt_q;
    end
  end

  // Sequencer state, reset counter, mode memory and registered pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      rst_cnt_q   <= '0;
      mode_halt_q <= START_HALTED;
      rdy_q       <= 1'b1;
      res_n_q     <= 1'b0;
      led_run_q   <= 1'b0;
      led_halt_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      mode_halt_q <= mode_halt_d;
      rdy_q       <= rdy_d;
      res_n_q     <= res_n_d;
      led_run_q   <= led_run_d;
      led_halt_q  <= led_halt_d;
      busy_q      <= busy_d;
    end
  end

  // PHI2 history for edge detection and the NMI pulse state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi2_q    <= 1'b0;
      nmi_n_q   <= 1'b1;
      nmi_cnt_q <= '0;
    end else begin
      phi2_q    <= phi2;
      nmi_n_q   <= nmi_n_d;
      nmi_cnt_q <= nmi_cnt_d;
    end
  end

  assign rdy      = rdy_q;
  assign res_n    = res_n_q;
  assign nmi_n    = nmi_n_q;
  assign led_run  = led_run_q;
  assign led_halt = led_halt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_run_control.sv
`timescale 1ns/1ps
// tb_run_control: directed bench for run_control with a 1 MHz PHI2 / 6502
// bus model. The model advances one CPU cycle per PHI2 falling edge while RDY
// is high, asserts SYNC on every third cycle, and counts completed opcode
// fetches as executed instructions.
module tb_run_control;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic phi2 = 1'b0;
  logic sync = 1'b1;
  logic b_runhalt = 1'b0;
  logic b_step = 1'b0;
  logic b_reset = 1'b0;
  logic b_nmi = 1'b0;
  logic rdy, res_n, nmi_n, led_run, led_halt, busy;

  int total = 0;
  int bad = 0;
  int phase = 0;
  int cyc = 0;
  int inst_cnt = 0;
  int fe_low_cnt = 0;
  logic mon_phi2_q = 1'b0;
  logic mon_resn_q = 1'b0;
  logic mon_rstn_q = 1'b0;

  always #20 clk = ~clk;

  run_control dut (
    .clk(clk), .rst_n(rst_n), .phi2(phi2), .sync(sync),
    .b_runhalt(b_runhalt), .b_step(b_step), .b_reset(b_reset), .b_nmi(b_nmi),
    .rdy(rdy), .res_n(res_n), .nmi_n(nmi_n),
    .led_run(led_run), .led_halt(led_halt), .busy(busy)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rdy_low(input int budget);
    for (int i = 0; i < budget && rdy !== 1'b0; i++) tick();
  endtask

  task automatic check_reset_pins(input string tag);
    check_value({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    check_value({tag, "_res_n"}, {31'd0, res_n}, 32'd0);
    check_value({tag, "_nmi_n"}, {31'd0, nmi_n}, 32'd1);
    check_value({tag, "_led_run"}, {31'd0, led_run}, 32'd0);
    check_value({tag, "_led_halt"}, {31'd0, led_halt}, 32'd0);
    check_value({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // PHI2 / CPU bus model: 13 clk low, 12 clk high; a cycle completes at fe
  // only if RDY is high at that moment.
  initial forever begin
    @(negedge clk);
    if (phase == 24) begin
      phase = 0;
      phi2 = 1'b0;
      if (rdy === 1'b1) begin
        if (sync) inst_cnt++;
        cyc++;
      end
      sync = (cyc % 3 == 0);
    end else begin
      phase++;
      if (phase == 13) phi2 = 1'b1;
    end
  end

  // Counts PHI2 falling edges seen by the DUT while res_n was low.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && mon_rstn_q && mon_phi2_q && !phi2 && mon_resn_q === 1'b0) fe_low_cnt++;
    mon_phi2_q = phi2;
    mon_resn_q = res_n;
    mon_rstn_q = rst_n;
  end

  initial begin
    int found, lat, high, base, low, rdy_bad, fe_base;

    // Power-on reset
    #5 rst_n = 1'b0;
    tick();
    tick();
    check_reset_pins("por");
    rst_n = 1'b1;
    for (int i = 0; i < 600 && res_n !== 1'b1; i++) tick();
    check_value("por_res_n_rel", {31'd0, res_n}, 32'd1);
    check_value("por_fe_count", fe_low_cnt, 32'd8);
    check_value("run_rdy", {31'd0, rdy}, 32'd1);
    check_value("run_led_run", {31'd0, led_run}, 32'd1);
    check_value("run_led_halt", {31'd0, led_halt}, 32'd0);
    check_value("run_busy", {31'd0, busy}, 32'd0);

    // Halt at the next boundary
    b_runhalt = 1'b1; tick(); b_runhalt = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (sync && !phi2) begin
        found = 1;
        break;
      end
    end
    check_value("halt_bnd_seen", found, 32'd1);
    lat = 0;
    while (rdy !== 1'b0 && lat < 4) begin
      tick();
      lat++;
    end
    check_value("halt_lat_ok", {31'd0, (lat <= 3)}, 32'd1);
    check_value("halt_rdy", {31'd0, rdy}, 32'd0);
    check_value("halt_led_halt", {31'd0, led_halt}, 32'd1);
    check_value("halt_led_run", {31'd0, led_run}, 32'd0);
    check_value("halt_busy", {31'd0, busy}, 32'd0);
    base = inst_cnt;
    high = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (rdy !== 1'b0) high++;
    end
    check_value("halt_rdy_hold", high, 32'd0);
    check_value("halt_no_inst", inst_cnt - base, 32'd0);

    // Single step five times
    base = inst_cnt;
    for (int s = 0; s < 5; s++) begin
      b_step = 1'b1; tick(); b_step = 1'b0;
      check_value("step_rdy_up", {31'd0, rdy}, 32'd1);
      check_value("step_busy", {31'd0, busy}, 32'd1);
      wait_rdy_low(200);
      check_value("step_rdy_down", {31'd0, rdy}, 32'd0);
      check_value("step_inst", inst_cnt - base, s + 1);
    end
    check_value("step_led_halt", {31'd0, led_halt}, 32'd1);
    check_value("step_busy_end", {31'd0, busy}, 32'd0);

    // NMI is non-retriggerable
    b_nmi = 1'b1; tick(); b_nmi = 1'b0;
    low = 0;
    for (int i = 0; i < 300; i++) begin
      if (nmi_n !== 1'b1) low++;
      if (i == 50) b_nmi = 1'b1;
      if (i == 51) b_nmi = 1'b0;
      tick();
    end
    check_value("nmi_width", low, 32'd128);

    // NMI and reset together, from HALTED
    b_nmi = 1'b1; b_reset = 1'b1; tick(); b_nmi = 1'b0; b_reset = 1'b0;
    check_value("nmirst_nmi_n", {31'd0, nmi_n}, 32'd0);
    check_value("nmirst_res_n", {31'd0, res_n}, 32'd0);
    check_value("nmirst_rdy", {31'd0, rdy}, 32'd1);
    fe_base = fe_low_cnt;
    rdy_bad = 0;
    for (int i = 0; i < 600 && res_n !== 1'b1; i++) begin
      tick();
      if (rdy !== 1'b1) rdy_bad++;
    end
    check_value("hrst_res_n_rel", {31'd0, res_n}, 32'd1);
    check_value("hrst_fe_count", fe_low_cnt - fe_base, 32'd8);
    check_value("hrst_rdy_high", rdy_bad, 32'd0);
    check_value("hrst_halting_led_run", {31'd0, led_run}, 32'd1);
    check_value("hrst_halting_busy", {31'd0, busy}, 32'd1);
    wait_rdy_low(200);
    check_value("hrst_halt_rdy", {31'd0, rdy}, 32'd0);
    check_value("hrst_halt_led_halt", {31'd0, led_halt}, 32'd1);
    check_value("hrst_halt_busy", {31'd0, busy}, 32'd0);

    // run/halt beats step on the same clk
    b_runhalt = 1'b1; b_step = 1'b1; tick(); b_runhalt = 1'b0; b_step = 1'b0;
    check_value("prio_rdy", {31'd0, rdy}, 32'd1);
    check_value("prio_led_run", {31'd0, led_run}, 32'd1);
    check_value("prio_busy", {31'd0, busy}, 32'd0);
    check_value("prio_led_halt", {31'd0, led_halt}, 32'd0);

    // Async reset while in STEP_WAIT
    b_runhalt = 1'b1; tick(); b_runhalt = 1'b0;
    wait_rdy_low(200);
    check_value("sw_halted", {31'd0, rdy}, 32'd0);
    base = inst_cnt;
    b_step = 1'b1; tick(); b_step = 1'b0;
    for (int i = 0; i < 100 && inst_cnt == base; i++) tick();
    tick();
    tick();
    check_value("sw_in_step_busy", {31'd0, busy}, 32'd1);
    check_value("sw_in_step_rdy", {31'd0, rdy}, 32'd1);
    #5 rst_n = 1'b0;
    #1;
    check_reset_pins("midstep");
    #50 rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
